// File: rtl/pulse_counter.sv
// pulse_counter: CHANNELS independent pulse counters sharing one terminal count.
// Each channel counts qualified pulses up to N = max(termCount,1). When it
// reaches N it emits a one-cycle registered pulse on pulseOut. In one-shot
// mode the channel then halts and sets its done flag.
// Optional readback port: define PULSE_COUNTER_READ_EN to add sel/countOut.
module pulse_counter #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    // One extra bit so that an out-of-range channel index can be expressed
    localparam int SEL_W   = $clog2(CHANNELS) + 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                En,
    input  logic                mode,
    input  logic [WIDTH-1:0]    termCount,
    input  logic [CHANNELS-1:0] pulseIn,
    input  logic [CHANNELS-1:0] clear,
`ifdef PULSE_COUNTER_READ_EN
    input  logic [SEL_W-1:0]    sel,
    output logic [WIDTH-1:0]    countOut,
`endif
    output logic [CHANNELS-1:0] pulseOut,
    output logic [CHANNELS-1:0] done
);

    typedef enum logic {
        COUNTING = 1'b0,
        HALTED   = 1'b1
    } state_t;

    state_t              state     [CHANNELS];
    state_t              stateNext [CHANNELS];
    logic [WIDTH-1:0]    count     [CHANNELS];
    logic [WIDTH-1:0]    countNext [CHANNELS];
    logic [CHANNELS-1:0] terminal;
    logic [CHANNELS-1:0] pulseNext;
    logic [CHANNELS-1:0] doneNext;
    logic [WIDTH-1:0]    limit;

    // Last count value before wrap; termCount of zero is treated as one
    always_comb begin
        limit = '0;
        if (termCount != '0) begin
            limit = termCount - WIDTH'(1);
        end
    end

    // A terminal pulse is a counted pulse that lands at or past N-1; clear overrides it
    always_comb begin
        terminal = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            terminal[i] = (state[i] == COUNTING) && En && pulseIn[i] &&
                          !clear[i] && (count[i] >= limit);
        end
    end

    // Per-channel state and count registers, cleared immediately on reset
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= COUNTING;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= stateNext[i];
                count[i] <= countNext[i];
            end
        end
    end

    // Next state and count: clear re-arms, HALTED is left only by clear or reset
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            stateNext[i] = state[i];
            countNext[i] = count[i];
            if (clear[i]) begin
                stateNext[i] = COUNTING;
                countNext[i] = '0;
            end else if (state[i] == COUNTING && En && pulseIn[i]) begin
                if (terminal[i]) begin
                    countNext[i] = '0;
                    stateNext[i] = mode ? HALTED : COUNTING;
                end else begin
                    countNext[i] = count[i] + WIDTH'(1);
                end
            end
        end
    end

    // Output decode: pulse follows a terminal event, done latches on one-shot completion
    always_comb begin
        pulseNext = terminal;
        doneNext  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (clear[i]) begin
                doneNext[i] = 1'b0;
            end else begin
                doneNext[i] = done[i] | (terminal[i] & mode);
            end
        end
    end

    // Registered outputs so pulseOut is glitch-free and exactly one cycle late
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pulseOut <= '0;
            done     <= '0;
        end else begin
            pulseOut <= pulseNext;
            done     <= doneNext;
        end
    end

`ifdef PULSE_COUNTER_READ_EN
    // Registered readback of the selected channel count; unknown channels read zero
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            countOut <= '0;
        end else begin
            countOut <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SEL_W'(i)) begin
                    countOut <= count[i];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pulse_counter.sv
// tb_pulse_counter: directed scoreboard bench for pulse_counter (CHANNELS=4, WIDTH=8).
// Stimulus pushes the hand-computed {pulseOut,done} expected after each edge;
// a monitor pops and compares one entry after every rising edge.
module tb_pulse_counter;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic       mode;
    logic [7:0] termCount;
    logic [3:0] pulseIn;
    logic [3:0] clear;
    logic [3:0] pulseOut;
    logic [3:0] done;
`ifdef PULSE_COUNTER_READ_EN
    logic [2:0] sel;
    logic [7:0] countOut;
`endif

    typedef struct {
        logic [7:0] resp;
        string      name;
    } entry_t;

    entry_t sb[$];
    int     testsRun  = 0;
    int     failCount = 0;

    pulse_counter #(.CHANNELS(4), .WIDTH(8)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .En        (En),
        .mode      (mode),
        .termCount (termCount),
        .pulseIn   (pulseIn),
        .clear     (clear),
`ifdef PULSE_COUNTER_READ_EN
        .sel       (sel),
        .countOut  (countOut),
`endif
        .pulseOut  (pulseOut),
        .done      (done)
    );

    // Free-running clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic applyStimulus(input string name, input logic en, input logic md,
                                 input logic [7:0] tc, input logic [3:0] pin,
                                 input logic [3:0] clr, input logic [3:0] expPulse,
                                 input logic [3:0] expDone);
        entry_t e;
        @(negedge Clk);
        En        = en;
        mode      = md;
        termCount = tc;
        pulseIn   = pin;
        clear     = clr;
        e.resp    = {expPulse, expDone};
        e.name    = name;
        sb.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the scoreboard after each rising edge
    initial begin
        entry_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput(e.name, {8'h00, pulseOut, done}, {8'h00, e.resp});
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        Rst       = 1'b1;
        En        = 1'b0;
        mode      = 1'b0;
        termCount = 8'd0;
        pulseIn   = 4'b0;
        clear     = 4'b0;
`ifdef PULSE_COUNTER_READ_EN
        sel       = 3'd0;
`endif
        repeat (2) @(negedge Clk);
        checkOutput("reset", {8'h00, pulseOut, done}, 16'h0000);
        Rst = 1'b0;

        // Auto-reload, N=10: fires after pulses 10, 20, 30 (30 proves count was 5 after 25)
        for (int k = 1; k <= 30; k++) begin
            applyStimulus("reload10", 1, 0, 8'd10, 4'b0001, 4'b0000,
                          (k % 10 == 0) ? 4'b0001 : 4'b0000, 4'b0000);
        end
        applyStimulus("reload_idle", 1, 0, 8'd10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // One-shot, N=3 on channel 1
        applyStimulus("clr_all", 1, 0, 8'd3, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus("oneshot", 1, 1, 8'd3, 4'b0010, 4'b0000,
                          (k == 3) ? 4'b0010 : 4'b0000, (k >= 3) ? 4'b0010 : 4'b0000);
        end
        for (int k = 1; k <= 2; k++) begin
            applyStimulus("halt_mode0", 1, 0, 8'd3, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        end
        applyStimulus("rearm", 1, 1, 8'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus("oneshot2", 1, 1, 8'd3, 4'b0010, 4'b0000,
                          (k == 3) ? 4'b0010 : 4'b0000, (k == 3) ? 4'b0010 : 4'b0000);
        end
        applyStimulus("halt_en0", 0, 1, 8'd3, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        applyStimulus("clr_en0", 0, 1, 8'd3, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

        // Lowering termCount mid-count fires on the next pulse
        for (int k = 1; k <= 7; k++) begin
            applyStimulus("tc10_count", 1, 0, 8'd10, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        end
        applyStimulus("tc_lowered", 1, 0, 8'd4, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus("tc4_after", 1, 0, 8'd4, 4'b0001, 4'b0000,
                          (k == 4) ? 4'b0001 : 4'b0000, 4'b0000);
        end

        // Clear beats a pulse at count N-1 on channel 2
        for (int k = 1; k <= 2; k++) begin
            applyStimulus("ch2_count", 1, 0, 8'd3, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        end
        applyStimulus("clr_vs_pulse", 1, 0, 8'd3, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus("ch2_after", 1, 0, 8'd3, 4'b0100, 4'b0000,
                          (k == 3) ? 4'b0100 : 4'b0000, 4'b0000);
        end

        // En low holds count on channel 3
        for (int k = 1; k <= 2; k++) begin
            applyStimulus("ch3_count", 1, 0, 8'd3, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        end
        for (int k = 1; k <= 3; k++) begin
            applyStimulus("en_hold", 0, 0, 8'd3, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        end
        applyStimulus("en_resume", 1, 0, 8'd3, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
        applyStimulus("en_drop", 0, 0, 8'd3, 4'b1000, 4'b0000, 4'b0000, 4'b0000);

        // All channels fire together; pulse does not persist with pulseIn held
        applyStimulus("clr_all2", 1, 0, 8'd2, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        applyStimulus("multi1", 1, 0, 8'd2, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus("multi2", 1, 0, 8'd2, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
        applyStimulus("multi3", 1, 0, 8'd2, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus("multi4", 1, 0, 8'd2, 4'b1111, 4'b0000, 4'b1111, 4'b0000);

        // termCount=0 acts as N=1: pulse every cycle
        for (int k = 1; k <= 3; k++) begin
            applyStimulus("n_one", 1, 0, 8'd0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        end

        // Async reset mid-count and while halted discards everything
        applyStimulus("clr_all3", 1, 0, 8'd2, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        applyStimulus("ch1_os1", 1, 1, 8'd2, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus("ch1_os2", 1, 1, 8'd2, 4'b0010, 4'b0000, 4'b0010, 4'b0010);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus("pre_reset", 1, 0, 8'd10, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
        end
        @(negedge Clk);
        pulseIn = 4'b0000;
        #2 Rst = 1'b1;
        #1 checkOutput("async_reset", {8'h00, pulseOut, done}, 16'h0000);
        @(negedge Clk);
        Rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus("post_reset", 1, 0, 8'd10, 4'b0001, 4'b0000,
                          (k == 10) ? 4'b0001 : 4'b0000, 4'b0000);
        end

`ifdef PULSE_COUNTER_READ_EN
        // Count readback on channel 3 and an out-of-range index
        for (int k = 1; k <= 4; k++) begin
            applyStimulus("ch3_read", 1, 0, 8'd10, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        end
        @(negedge Clk);
        pulseIn = 4'b0000;
        sel     = 3'd3;
        @(posedge Clk);
        #1 checkOutput("countOut_sel3", {8'h00, countOut}, 16'd4);
        @(negedge Clk);
        sel = 3'd5;
        @(posedge Clk);
        #1 checkOutput("countOut_sel5", {8'h00, countOut}, 16'd0);
`endif

        repeat (3) @(negedge Clk);
        checkOutput("sb_drain", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
